// File: rtl/mux_scan_pkg.sv
// Shared definitions for the selector scan sequencer.
// Provides the FSM state type, channel/data sizing and the
// helper that finds the next channel to scan from a channel mask.
package mux_scan_pkg;

  localparam int NCH    = 4;
  localparam int DATA_W = 2 * NCH;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Lowest set mask bit strictly above 'cur'. Bit 2 of the result is set
  // when no such channel exists. Pass cur = -1 to find the first channel.
  function automatic logic [2:0] next_ch(input logic [NCH-1:0] mask, input int cur);
    logic [2:0] r;
    r = 3'b100;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (k > cur && mask[k]) r = {1'b0, k[1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_settle_ctr.sv
// Loadable down counter used to hold the selector lines stable for a
// fixed number of clocks before the selector outputs are sampled.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   load     - load load_val (has priority over counting)
//   en       - decrement by one while the count is non-zero
//   load_val - value loaded on load
//   zero     - count is zero
module mux_scan_settle_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  // The counter saturates at zero so a stray enable cannot wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer for a dual 4-line-to-1-line selector. On an accepted
// start it walks the requested channels, drives SEL1:SEL0 and the active-low
// group enables, waits SETTLE_CYCLES clocks per channel, samples G1Q/G2Q into
// an 8-bit snapshot and offers it with a valid/ack handshake.
// Ports:
//   clk, reset_n     - clock and asynchronous active-low reset
//   start            - request pulse, taken only in IDLE
//   ch_mask, grp_en  - channels and groups to scan, latched at start
//   ack              - consumer takes the snapshot while valid
//   sel0, sel1       - selector channel select
//   enb1_n, enb2_n   - selector group enables, active low
//   g1q, g2q         - selector outputs
//   busy, valid      - scan in progress / snapshot available
//   data             - snapshot, data[2k]=group1 ch k, data[2k+1]=group2 ch k
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [1:0]        grp_en,
  input  logic              ack,
  output logic              sel0,
  output logic              sel1,
  output logic              enb1_n,
  output logic              enb2_n,
  input  logic              g1q,
  input  logic              g2q,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  state_t            state_r, state_nxt;
  logic [1:0]        ch_r, ch_nxt;
  logic [NCH-1:0]    mask_r, mask_nxt;
  logic [1:0]        grp_r, grp_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              enb1_nxt, enb2_nxt, busy_nxt, valid_nxt;
  logic              ctr_load, ctr_en, ctr_zero;
  logic [2:0]        nx;

  mux_scan_settle_ctr #(.CW(CW)) u_settle (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (CW'(SETTLE_CYCLES)),
    .zero     (ctr_zero)
  );

  // All outputs come straight from these registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ch_r    <= '0;
      mask_r  <= '0;
      grp_r   <= '0;
      data    <= '0;
      enb1_n  <= 1'b1;
      enb2_n  <= 1'b1;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      ch_r    <= ch_nxt;
      mask_r  <= mask_nxt;
      grp_r   <= grp_nxt;
      data    <= data_nxt;
      enb1_n  <= enb1_nxt;
      enb2_n  <= enb2_nxt;
      busy    <= busy_nxt;
      valid   <= valid_nxt;
    end
  end

  assign sel0 = ch_r[0];
  assign sel1 = ch_r[1];

  // Next-state logic. An empty mask or no enabled group skips the
  // selector entirely and reports an all-zero snapshot one edge later.
  always_comb begin
    state_nxt = state_r;
    ch_nxt    = ch_r;
    mask_nxt  = mask_r;
    grp_nxt   = grp_r;
    data_nxt  = data;
    enb1_nxt  = enb1_n;
    enb2_nxt  = enb2_n;
    busy_nxt  = busy;
    valid_nxt = valid;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    nx        = '0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mask_nxt = ch_mask;
          grp_nxt  = grp_en;
          data_nxt = '0;
          if (ch_mask == '0 || grp_en == 2'b00) begin
            valid_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            nx        = next_ch(ch_mask, -1);
            ch_nxt    = nx[1:0];
            ctr_load  = 1'b1;
            enb1_nxt  = ~grp_en[0];
            enb2_nxt  = ~grp_en[1];
            busy_nxt  = 1'b1;
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (!ctr_zero) begin
          ctr_en = 1'b1;
        end else begin
          data_nxt[{ch_r, 1'b0}] = g1q & grp_r[0];
          data_nxt[{ch_r, 1'b1}] = g2q & grp_r[1];
          nx = next_ch(mask_r, int'(ch_r));
          if (!nx[2]) begin
            ch_nxt   = nx[1:0];
            ctr_load = 1'b1;
          end else begin
            ch_nxt    = '0;
            enb1_nxt  = 1'b1;
            enb2_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            valid_nxt = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq. A behavioural selector model maps
// each channel to a random truth table; expected snapshots and latencies
// are computed from the channel mask, group enables and settle count.
module tb_mux_scan_seq;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, ack = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [1:0] grp_en = '0;
  logic       sel0, sel1, enb1_n, enb2_n, g1q, g2q, busy, valid;
  logic [7:0] data;

  logic       start0 = 1'b0, ack0 = 1'b0;
  logic       sel0_0, sel1_0, enb1_n0, enb2_n0, g1q0, g2q0, busy0, valid0;
  logic [7:0] data0;

  logic [7:0] tbl = '0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mux_scan_seq #(.SETTLE_CYCLES(S), .CW(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ch_mask(ch_mask), .grp_en(grp_en),
    .ack(ack), .sel0(sel0), .sel1(sel1), .enb1_n(enb1_n), .enb2_n(enb2_n),
    .g1q(g1q), .g2q(g2q), .busy(busy), .valid(valid), .data(data)
  );

  mux_scan_seq #(.SETTLE_CYCLES(0), .CW(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .ch_mask(ch_mask), .grp_en(grp_en),
    .ack(ack0), .sel0(sel0_0), .sel1(sel1_0), .enb1_n(enb1_n0), .enb2_n(enb2_n0),
    .g1q(g1q0), .g2q(g2q0), .busy(busy0), .valid(valid0), .data(data0)
  );

  // Selector model: a disabled group drives 0, an enabled group drives the
  // truth-table bit of the selected channel.
  always_comb begin
    g1q  = !enb1_n  && tbl[{sel1, sel0, 1'b0}];
    g2q  = !enb2_n  && tbl[{sel1, sel0, 1'b1}];
    g1q0 = !enb1_n0 && tbl[{sel1_0, sel0_0, 1'b0}];
    g2q0 = !enb2_n0 && tbl[{sel1_0, sel0_0, 1'b1}];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expSnapshot(input logic [3:0] m, input logic [1:0] g, input logic [7:0] t);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        r[2*k]   = t[2*k]   & g[0];
        r[2*k+1] = t[2*k+1] & g[1];
      end
    end
    return r;
  endfunction

  // Issue one request on the main instance, follow it to valid and check
  // latency, snapshot and the selector activity seen during the scan.
  task automatic applyStimulus(input string tag, input logic [3:0] m, input logic [1:0] g);
    int e, lat;
    logic s1, s2, sel_seen, busy_bad;
    bit active;
    active = (m != 0) && (g != 0);
    lat = active ? $countones(m) * (S + 1) : 0;
    @(negedge clk);
    ch_mask = m; grp_en = g; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e = 0; s1 = 0; s2 = 0; sel_seen = 0; busy_bad = 0;
    @(negedge clk);
    while (valid !== 1'b1 && e < 200) begin
      if (enb1_n === 1'b0) s1 = 1;
      if (enb2_n === 1'b0) s2 = 1;
      if ({sel1, sel0} != 2'b00) sel_seen = 1;
      if (busy !== 1'b1) busy_bad = 1;
      @(posedge clk); e++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, e, lat);
    checkOutput({tag, "_data"}, data, expSnapshot(m, g, tbl));
    checkOutput({tag, "_busy_scan"}, busy_bad, 0);
    checkOutput({tag, "_enb1_used"}, s1, active && g[0]);
    checkOutput({tag, "_enb2_used"}, s2, active && g[1]);
    checkOutput({tag, "_idle_lines"}, {busy, enb2_n, enb1_n, sel1, sel0}, 5'b01100);
    if (!active) checkOutput({tag, "_no_sel"}, sel_seen, 0);
  endtask

  task automatic doAck(input string tag);
    logic [7:0] held;
    held = data;
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ack_valid"}, valid, 0);
    checkOutput({tag, "_ack_data"}, data, held);
  endtask

  initial begin
    logic [7:0] exp_d;
    // Reset state
    #12;
    checkOutput("reset_state", {valid, busy, enb2_n, enb1_n, sel1, sel0, data}, {6'b001100, 8'h00});
    @(negedge clk); reset_n = 1'b1;

    // Fixed mapping ch k -> g1q=k[0], g2q=k[1]
    tbl = 8'b11_10_01_00;
    applyStimulus("all_ch", 4'b1111, 2'b11);
    doAck("all_ch");

    tbl = 8'hFF;
    applyStimulus("grp1_ch02", 4'b0101, 2'b01);
    doAck("grp1_ch02");
    applyStimulus("empty_mask", 4'b0000, 2'b11);
    doAck("empty_mask");
    applyStimulus("no_grp", 4'b1010, 2'b00);
    doAck("no_grp");

    // Reset mid-scan at edge 5
    @(negedge clk);
    ch_mask = 4'b1111; grp_en = 2'b11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 checkOutput("midscan_reset", {valid, busy, enb2_n, enb1_n, sel1, sel0, data}, {6'b001100, 8'h00});
    @(negedge clk); reset_n = 1'b1;
    tbl = 8'($urandom);
    applyStimulus("after_reset", 4'b1111, 2'b11);

    // Hold without ack while pulsing start: snapshot must not move
    exp_d = expSnapshot(4'b1111, 2'b11, tbl);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = 1'b1; ch_mask = 4'b0001; ack = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checkOutput("hold", {valid, busy, enb1_n, data}, {3'b101, exp_d});
    end

    // start and ack together: ack wins, no new scan begins
    @(negedge clk); start = 1'b1; ack = 1'b1; ch_mask = 4'b1111;
    @(posedge clk); #1 begin start = 1'b0; ack = 1'b0; end
    @(negedge clk);
    checkOutput("start_ack_same", {valid, busy, enb2_n, enb1_n, data}, {4'b0011, exp_d});
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("no_new_scan", {valid, busy, enb1_n}, 3'b001);

    // Randomized requests
    for (int i = 0; i < 8; i++) begin
      tbl = 8'($urandom);
      applyStimulus("random", 4'($urandom), 2'($urandom));
      doAck("random");
    end

    // Zero settle: channel 3 alone, sel=11 for one cycle, valid after edge 1
    tbl = 8'($urandom);
    @(negedge clk);
    ch_mask = 4'b1000; grp_en = 2'b11; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    checkOutput("s0_edge0", {valid0, busy0, enb2_n0, enb1_n0, sel1_0, sel0_0}, 6'b010011);
    @(negedge clk);
    checkOutput("s0_edge1", {valid0, busy0, enb2_n0, enb1_n0, sel1_0, sel0_0}, 6'b101100);
    checkOutput("s0_data", data0, expSnapshot(4'b1000, 2'b11, tbl));
    @(negedge clk); ack0 = 1'b1;
    @(posedge clk); #1 ack0 = 1'b0;
    @(negedge clk);
    checkOutput("s0_ack", valid0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
